// File: rtl/dct_pkg.sv
// Shared types and sizing helpers for the DCT block scheduler.
// Contents: writer/reader state enums and a counter-width helper.
package dct_pkg;

   typedef enum logic {
      WR_IDLE  = 1'b0,
      WR_WRITE = 1'b1
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      if (n <= 32'd1) return 32'd1;
      return 32'($clog2(n));
   endfunction

endpackage

// File: rtl/block_addr_gen.sv
// Block-order read address generator for one stripe bank.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear of all counters (frame restart)
//   advance       step to the next sample of the stripe
//   addr          r*WIDTH + b*BLK + c within the bank
//   sob, eob      current sample is first / last of its block
//   last          current sample is the final sample of the stripe
module block_addr_gen
   import dct_pkg::*;
#(
   parameter int unsigned WIDTH = 1280,
   parameter int unsigned BLK   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         advance,
   output logic [$clog2(BLK*WIDTH)-1:0] addr,
   output logic                         sob,
   output logic                         eob,
   output logic                         last
);

   localparam int unsigned STRIPE_PIX      = BLK * WIDTH;
   localparam int unsigned ADDR_W          = $clog2(STRIPE_PIX);
   localparam int unsigned BLKS_PER_STRIPE = WIDTH / BLK;
   localparam int unsigned C_W             = cnt_w(BLK);
   localparam int unsigned B_W             = cnt_w(BLKS_PER_STRIPE);

   logic [C_W-1:0] c_q;
   logic [C_W-1:0] r_q;
   logic [B_W-1:0] b_q;
   logic           c_last;
   logic           r_last;
   logic           b_last;

   assign c_last = (c_q == C_W'(BLK - 1));
   assign r_last = (r_q == C_W'(BLK - 1));
   assign b_last = (b_q == B_W'(BLKS_PER_STRIPE - 1));

   // Address math at full bank width so the row product is never truncated.
   assign addr = ADDR_W'(r_q) * ADDR_W'(WIDTH)
               + ADDR_W'(b_q) * ADDR_W'(BLK)
               + ADDR_W'(c_q);

   assign sob  = (c_q == C_W'(0)) && (r_q == C_W'(0));
   assign eob  = c_last && r_last;
   assign last = eob && b_last;

   // Nesting, innermost first: column, row, block.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         c_q <= '0;
         r_q <= '0;
         b_q <= '0;
      end else if (advance) begin
         if (!c_last) begin
            c_q <= c_q + C_W'(1);
         end else begin
            c_q <= '0;
            if (!r_last) begin
               r_q <= r_q + C_W'(1);
            end else begin
               r_q <= '0;
               b_q <= b_last ? '0 : b_q + B_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/dct_block_scheduler.sv
// Raster-to-8x8-block scheduler driving an external two-bank stripe buffer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start              start (or restart) a frame
//   pix_valid                raster pixel present this cycle
//   wr_en/wr_bank/wr_addr    buffer write port (address combinational)
//   rd_en/rd_bank/rd_addr    buffer read port, 1-cycle RAM latency
//   dct_ready                DCT can take a sample next cycle
//   dct_valid/sob/eob        sample strobe and block framing, aligned to RAM data
//   frame_done               last sample of the frame presented
//   overflow                 pixel dropped, target bank still full
//   busy                     frame in progress
module dct_block_scheduler
   import dct_pkg::*;
#(
   parameter int unsigned WIDTH  = 1280,
   parameter int unsigned HEIGHT = 720,
   parameter int unsigned BLK    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         pix_valid,
   output logic                         wr_en,
   output logic                         wr_bank,
   output logic [$clog2(BLK*WIDTH)-1:0] wr_addr,
   output logic                         rd_en,
   output logic                         rd_bank,
   output logic [$clog2(BLK*WIDTH)-1:0] rd_addr,
   input  logic                         dct_ready,
   output logic                         dct_valid,
   output logic                         dct_sob,
   output logic                         dct_eob,
   output logic                         frame_done,
   output logic                         overflow,
   output logic                         busy
);

   localparam int unsigned STRIPE_PIX = BLK * WIDTH;
   localparam int unsigned ADDR_W     = $clog2(STRIPE_PIX);
   localparam int unsigned N_STRIPES  = HEIGHT / BLK;
   localparam int unsigned COL_W      = cnt_w(WIDTH);
   localparam int unsigned ROW_W      = cnt_w(BLK);
   localparam int unsigned STR_W      = cnt_w(N_STRIPES);

   wr_state_t        wr_state_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic [STR_W-1:0] wr_stripe_q;
   logic             wr_bank_q;

   rd_state_t        rd_state_q;
   logic [STR_W-1:0] rd_stripe_q;
   logic             rd_bank_q;

   logic [1:0]       full_q;
   logic [1:0]       full_d;

   logic             dct_valid_q;
   logic             dct_sob_q;
   logic             dct_eob_q;
   logic             frame_done_q;
   logic             busy_q;

   logic             wr_active;
   logic             wr_last_col;
   logic             wr_last_row;
   logic             wr_last_stripe;
   logic             rd_sob;
   logic             rd_eob;
   logic             rd_last;
   logic             rd_last_stripe;
   logic             rd_frame_end;

   // Writer strobes: counters advance on every pixel, the write is dropped if the bank is full.
   assign wr_active      = (wr_state_q == WR_WRITE) && pix_valid;
   assign wr_en          = wr_active && !full_q[wr_bank_q];
   assign overflow       = wr_active &&  full_q[wr_bank_q];
   assign wr_addr        = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
   assign wr_last_col    = (col_q == COL_W'(WIDTH - 1));
   assign wr_last_row    = (row_q == ROW_W'(BLK - 1));
   assign wr_last_stripe = (wr_stripe_q == STR_W'(N_STRIPES - 1));

   // Reader strobes: a stalled DCT simply freezes the address counters.
   assign rd_en          = (rd_state_q == RD_READ) && dct_ready;
   assign rd_last_stripe = (rd_stripe_q == STR_W'(N_STRIPES - 1));
   assign rd_frame_end   = rd_en && rd_last && rd_last_stripe;

   block_addr_gen #(
      .WIDTH (WIDTH),
      .BLK   (BLK)
   ) u_rd_addr (
      .clk     (clk),
      .rst     (rst),
      .clr     (frame_start),
      .advance (rd_en),
      .addr    (rd_addr),
      .sob     (rd_sob),
      .eob     (rd_eob),
      .last    (rd_last)
   );

   // Bank occupancy: writer sets only empty banks, reader clears only full ones.
   always_comb begin
      full_d = full_q;
      if (wr_en && wr_last_col && wr_last_row) full_d[wr_bank_q] = 1'b1;
      if (rd_en && rd_last)                    full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst || frame_start) full_q <= 2'b00;
      else                    full_q <= full_d;
   end

   // Writer FSM and raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= WR_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         wr_stripe_q <= '0;
         wr_bank_q   <= 1'b0;
      end else if (frame_start) begin
         wr_state_q  <= WR_WRITE;
         col_q       <= '0;
         row_q       <= '0;
         wr_stripe_q <= '0;
         wr_bank_q   <= 1'b0;
      end else if (wr_active) begin
         if (!wr_last_col) begin
            col_q <= col_q + COL_W'(1);
         end else begin
            col_q <= '0;
            if (!wr_last_row) begin
               row_q <= row_q + ROW_W'(1);
            end else begin
               row_q     <= '0;
               wr_bank_q <= ~wr_bank_q;
               if (wr_last_stripe) begin
                  wr_stripe_q <= '0;
                  wr_state_q  <= WR_IDLE;
               end else begin
                  wr_stripe_q <= wr_stripe_q + STR_W'(1);
               end
            end
         end
      end
   end

   // Reader FSM: drain a full bank, then hand it back to the writer.
   always_ff @(posedge clk) begin
      if (rst || frame_start) begin
         rd_state_q  <= RD_IDLE;
         rd_bank_q   <= 1'b0;
         rd_stripe_q <= '0;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (full_q[rd_bank_q]) rd_state_q <= RD_READ;
            end
            RD_READ: begin
               if (rd_en && rd_last) begin
                  rd_state_q  <= RD_IDLE;
                  rd_bank_q   <= ~rd_bank_q;
                  rd_stripe_q <= rd_last_stripe ? '0 : rd_stripe_q + STR_W'(1);
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   // DCT-side strobes delayed one cycle to line up with RAM read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         dct_valid_q  <= 1'b0;
         dct_sob_q    <= 1'b0;
         dct_eob_q    <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         dct_valid_q  <= rd_en;
         dct_sob_q    <= rd_en && rd_sob;
         dct_eob_q    <= rd_en && rd_eob;
         frame_done_q <= rd_frame_end && !frame_start;
         if (frame_start)       busy_q <= 1'b1;
         else if (rd_frame_end) busy_q <= 1'b0;
      end
   end

   assign wr_bank    = wr_bank_q;
   assign rd_bank    = rd_bank_q;
   assign dct_valid  = dct_valid_q;
   assign dct_sob    = dct_sob_q;
   assign dct_eob    = dct_eob_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Bench for dct_block_scheduler: a 16x16 instance for ordering and framing,
// plus a 16x32 instance (four stripes) so the writer can outrun a stalled reader.
module tb_dct_block_scheduler;

   localparam int TW  = 16;
   localparam int TB  = 8;
   localparam int NPX = 256;         // pixels in the 16x16 frame
   localparam int SP  = TW * TB;     // pixels per stripe / bank entries

   logic clk = 1'b0;
   logic rst = 1'b0, fs = 1'b0, pv = 1'b0, rdy = 1'b0;

   logic       a_wr_en, a_wr_bank, a_rd_en, a_rd_bank;
   logic [6:0] a_wr_addr, a_rd_addr;
   logic       a_dct_valid, a_dct_sob, a_dct_eob, a_frame_done, a_overflow, a_busy;

   logic       b_wr_en, b_wr_bank, b_rd_en, b_rd_bank;
   logic [6:0] b_wr_addr, b_rd_addr;
   logic       b_dct_valid, b_dct_sob, b_dct_eob, b_frame_done, b_overflow, b_busy;

   int checks = 0;
   int errors = 0;

   // Reference model state: the RAM contents as raster pixel indices.
   int mem [2][SP];
   int wr_idx, rd_seen, rd_issued, pend, fd_cnt;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   dct_block_scheduler #(.WIDTH(TW), .HEIGHT(16), .BLK(TB)) dut_a (
      .clk(clk), .rst(rst), .frame_start(fs), .pix_valid(pv),
      .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr),
      .rd_en(a_rd_en), .rd_bank(a_rd_bank), .rd_addr(a_rd_addr),
      .dct_ready(rdy), .dct_valid(a_dct_valid), .dct_sob(a_dct_sob),
      .dct_eob(a_dct_eob), .frame_done(a_frame_done), .overflow(a_overflow),
      .busy(a_busy));

   dct_block_scheduler #(.WIDTH(TW), .HEIGHT(32), .BLK(TB)) dut_b (
      .clk(clk), .rst(rst), .frame_start(fs), .pix_valid(pv),
      .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr),
      .rd_en(b_rd_en), .rd_bank(b_rd_bank), .rd_addr(b_rd_addr),
      .dct_ready(rdy), .dct_valid(b_dct_valid), .dct_sob(b_dct_sob),
      .dct_eob(b_dct_eob), .frame_done(b_frame_done), .overflow(b_overflow),
      .busy(b_busy));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Raster index of the n-th sample the DCT should receive.
   function automatic int exp_pos(input int n);
      int s, m, b, r, c;
      s = n / SP; m = n % SP; b = m / (TB*TB); r = (m % (TB*TB)) / TB; c = m % TB;
      return (s*TB + r)*TW + b*TB + c;
   endfunction

   // Bank address of the k-th read within a stripe.
   function automatic int exp_rd_addr(input int k);
      int m;
      m = k % SP;
      return ((m % (TB*TB)) / TB)*TW + (m / (TB*TB))*TB + (m % TB);
   endfunction

   // Scoreboard: writes land in the model RAM, reads must return raster pixels in block order.
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_dct_valid) begin
            if (rd_seen >= NPX) chk("extra_dct_valid", rd_seen, NPX - 1);
            else begin
               chk("blk_order_pix", pend, exp_pos(rd_seen));
               chk("dct_sob", a_dct_sob, (rd_seen % 64) == 0);
               chk("dct_eob", a_dct_eob, (rd_seen % 64) == 63);
               chk("frame_done", a_frame_done, rd_seen == NPX - 1);
               chk("busy_vs_done", a_busy, rd_seen != NPX - 1);
            end
            rd_seen++;
         end else begin
            chk("frame_done_no_valid", a_frame_done, 0);
         end
         if (a_frame_done) fd_cnt++;
         if (a_rd_en) begin
            pend = mem[a_rd_bank][a_rd_addr];
            mem[a_rd_bank][a_rd_addr] = -1;
            rd_issued++;
         end
         chk("wr_en_follows_pix", a_wr_en, pv);
         chk("no_overflow", a_overflow, 0);
         if (a_wr_en) begin
            chk("wr_slot_free", mem[a_wr_bank][a_wr_addr], -1);
            mem[a_wr_bank][a_wr_addr] = wr_idx;
         end
         if (pv) wr_idx++;
      end
   end

   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fs = 1'b0; pv = 1'b0; rdy = 1'b0;
      repeat (2) next_cyc();
      rst = 1'b0;
   endtask

   // DCT stall mid-block: counters freeze and no sample is emitted.
   task automatic stall5();
      int ea;
      ea = exp_rd_addr(rd_issued);
      rdy = 1'b0; pv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_rd_en", a_rd_en, 0);
         chk("stall_rd_addr", a_rd_addr, ea);
         if (i > 0) chk("stall_dct_valid", a_dct_valid, 0);
         next_cyc();
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("post_stall_valid", a_dct_valid, 0);
      chk("post_stall_rd_en", a_rd_en, 1);
      chk("post_stall_rd_addr", a_rd_addr, ea);
      next_cyc();
   endtask

   // mode 0: back-to-back, mode 1: random pixels/ready, mode 2: steady with one stall.
   task automatic run_frame(input int mode);
      int sent, cyc_n;
      bit stalled;
      for (int bk = 0; bk < 2; bk++)
         for (int ad = 0; ad < SP; ad++) mem[bk][ad] = -1;
      wr_idx = 0; rd_seen = 0; rd_issued = 0; pend = -1; fd_cnt = 0;
      fs = 1'b1; pv = 1'b0; rdy = 1'b1;
      next_cyc();
      fs = 1'b0;
      mon_en = 1'b1;
      sent = 0; cyc_n = 0; stalled = 1'b0;
      while ((sent < NPX || rd_seen < NPX) && cyc_n < 4000) begin
         if (mode == 2 && !stalled && rd_seen >= 20) begin
            stall5();
            stalled = 1'b1;
         end
         pv  = (sent < NPX) && (mode != 1 || $urandom_range(0, 3) != 0);
         rdy = (mode != 1) || ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (pv && sent == 0)  begin chk("first_wr_bank", a_wr_bank, 0); chk("first_wr_addr", a_wr_addr, 0); end
         if (pv && sent == SP) begin chk("second_wr_bank", a_wr_bank, 1); chk("second_wr_addr", a_wr_addr, 0); end
         if (pv) sent++;
         next_cyc();
         cyc_n++;
      end
      chk("frame_in_budget", cyc_n < 4000, 1);
      pv = 1'b0;
      repeat (4) next_cyc();
      mon_en = 1'b0;
      chk("dct_valid_count", rd_seen, NPX);
      chk("frame_done_count", fd_cnt, 1);
      chk("busy_after_frame", a_busy, 0);
   endtask

   typedef struct {
      bit rst, fs, pv, rdy;
      bit e_wr_en;
      int e_wr_addr;
      bit e_busy;
      bit e_rd_en;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      // rst fs pv rdy | wr_en wr_addr busy rd_en
      tbl[0]  = '{0, 0, 1, 0,  0, 0, 0, 0};   // no frame: pixels ignored
      tbl[1]  = '{0, 1, 1, 0,  0, 0, 0, 0};   // frame_start cycle, still IDLE
      tbl[2]  = '{0, 0, 1, 0,  1, 0, 1, 0};
      tbl[3]  = '{0, 0, 1, 0,  1, 1, 1, 0};
      tbl[4]  = '{0, 0, 0, 1,  0, 2, 1, 0};   // gap; reader has nothing yet
      tbl[5]  = '{0, 0, 1, 0,  1, 2, 1, 0};
      tbl[6]  = '{0, 1, 1, 0,  1, 3, 1, 0};   // restart mid-frame
      tbl[7]  = '{0, 0, 1, 0,  1, 0, 1, 0};   // counters restarted
      tbl[8]  = '{1, 0, 1, 0,  1, 1, 1, 0};   // reset applied at this edge
      tbl[9]  = '{0, 0, 1, 0,  0, 0, 0, 0};
      tbl[10] = '{0, 0, 1, 1,  0, 0, 0, 0};

      do_reset();
      @(negedge clk);
      chk("rst_outputs", {a_wr_en, a_wr_bank, a_rd_en, a_rd_bank, a_dct_valid, a_dct_sob,
                          a_dct_eob, a_frame_done, a_overflow, a_busy}, 0);
      chk("rst_addrs", {a_wr_addr, a_rd_addr}, 0);
      next_cyc();

      for (int i = 0; i < 11; i++) begin
         rst = tbl[i].rst; fs = tbl[i].fs; pv = tbl[i].pv; rdy = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_wr_en", i), a_wr_en, tbl[i].e_wr_en);
         chk($sformatf("vec%0d_wr_addr", i), a_wr_addr, tbl[i].e_wr_addr);
         chk($sformatf("vec%0d_busy", i), a_busy, tbl[i].e_busy);
         chk($sformatf("vec%0d_rd_en", i), a_rd_en, tbl[i].e_rd_en);
         chk($sformatf("vec%0d_misc", i), {a_wr_bank, a_overflow, a_dct_valid, a_frame_done}, 0);
         next_cyc();
      end
      rst = 1'b0; fs = 1'b0; pv = 1'b0; rdy = 1'b0;

      run_frame(0);
      run_frame(1);
      run_frame(2);

      // Overflow: four-stripe instance with the DCT stalled throughout.
      do_reset();
      fs = 1'b1; next_cyc(); fs = 1'b0;
      for (int i = 0; i < 2*SP + 1; i++) begin
         pv = 1'b1;
         @(negedge clk);
         if (i < 2*SP) begin
            chk("ovf_fill_wr_en", b_wr_en, 1);
            chk("ovf_fill_ovf", b_overflow, 0);
         end else begin
            chk("ovf_drop_wr_en", b_wr_en, 0);
            chk("ovf_drop_ovf", b_overflow, 1);
            chk("ovf_drop_bank", b_wr_bank, 0);
            chk("ovf_drop_addr", b_wr_addr, 0);
            chk("ovf_reader_idle", {b_rd_bank, b_rd_addr, b_dct_valid, b_dct_sob, b_dct_eob, b_frame_done}, 0);
            chk("ovf_busy", b_busy, 1);
         end
         chk("ovf_rd_en", b_rd_en, 0);
         next_cyc();
      end
      pv = 1'b0;
      @(negedge clk);
      chk("ovf_pulse_end", b_overflow, 0);
      next_cyc();

      // Restart during bank-0 readout.
      do_reset();
      fs = 1'b1; next_cyc(); fs = 1'b0;
      rdy = 1'b1; pv = 1'b1;
      repeat (SP) next_cyc();
      pv = 1'b0;
      repeat (10) next_cyc();
      fs = 1'b1;
      @(negedge clk);
      chk("abort_pre_rd_en", a_rd_en, 1);
      next_cyc();
      fs = 1'b0;
      @(negedge clk);
      chk("abort_rd_en", a_rd_en, 0);
      chk("abort_last_valid", a_dct_valid, 1);
      chk("abort_banks", {a_wr_bank, a_rd_bank}, 0);
      chk("abort_busy", a_busy, 1);
      next_cyc();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_reader_idle", a_rd_en, 0);
         chk("abort_no_valid", a_dct_valid, 0);
         next_cyc();
      end
      pv = 1'b1;
      @(negedge clk);
      chk("abort_wr_en", a_wr_en, 1);
      chk("abort_wr_addr", a_wr_addr, 0);
      chk("abort_wr_bank", a_wr_bank, 0);
      next_cyc();
      pv = 1'b0; rdy = 1'b0;
      next_cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
